// File: rtl/cpu_phase_gen.sv
// Eight-phase timing generator feeding the VeriRISC CPU: derives fetch, cntrl_clk
// and alu_clk from one master clock, with run/step/halt/resume control and a cycle counter.
module cpu_phase_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             run_en,
  input  logic             step,
  input  logic             resume,
  input  logic             halt,
  output logic             fetch,
  output logic             cntrl_clk,
  output logic             alu_clk,
  output logic             inst_done,
  output logic [2:0]       phase,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] inst_count
);

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       phase_d;
  logic             fetch_d, cntrl_d, alu_d, done_d;
  logic [CNT_W-1:0] count_d;
  logic             active, active_d, boundary;

  assign active   = (state_q == RUNNING) || (state_q == STEPPING);
  assign boundary = active && (phase == 3'd7);
  assign state    = state_q;

  // State register: every output is a flop, so no input reaches an output combinationally.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= STOPPED;
      phase      <= 3'd0;
      fetch      <= 1'b0;
      cntrl_clk  <= 1'b0;
      alu_clk    <= 1'b0;
      inst_done  <= 1'b0;
      inst_count <= '0;
    end else begin
      state_q    <= state_d;
      phase      <= phase_d;
      fetch      <= fetch_d;
      cntrl_clk  <= cntrl_d;
      alu_clk    <= alu_d;
      inst_done  <= done_d;
      inst_count <= count_d;
    end
  end

  // Next state: halt and run_en only matter at the instruction boundary.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      STOPPED: begin
        if (run_en)    state_d = RUNNING;
        else if (step) state_d = STEPPING;
      end
      RUNNING: begin
        if (boundary) state_d = halt ? HALTED : (run_en ? RUNNING : STOPPED);
      end
      STEPPING: begin
        if (boundary) state_d = halt ? HALTED : STOPPED;
      end
      HALTED: begin
        if (resume) state_d = STOPPED;
      end
      default: state_d = STOPPED;
    endcase
  end

  // Outputs are decoded from the phase being entered, so the start edge and a
  // back-to-back boundary both present the p=0 pattern immediately.
  always_comb begin
    active_d = (state_d == RUNNING) || (state_d == STEPPING);
    phase_d  = (active && active_d) ? phase + 3'd1 : 3'd0;
    fetch_d  = active_d && !phase_d[2];
    cntrl_d  = active_d && !phase_d[0];
    alu_d    = active_d && (phase_d[2:1] == 2'b10);
    done_d   = boundary;
    count_d  = inst_count;
    if (boundary && (inst_count != '1)) count_d = inst_count + CNT_ONE;
  end

endmodule

// File: tb/tb_cpu_phase_gen.sv
// Bench for cpu_phase_gen: a cycle-position model checked every clock on two instances
// (CNT_W=16 and CNT_W=2) plus directed scenarios with literal expectations.
module tb_cpu_phase_gen;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic run_en = 1'b0, step = 1'b0, resume = 1'b0, halt = 1'b0;

  logic        fetch_a, cntrl_a, alu_a, done_a;
  logic [2:0]  phase_a;
  logic [1:0]  state_a;
  logic [15:0] count_a;

  logic        fetch_b, cntrl_b, alu_b, done_b;
  logic [2:0]  phase_b;
  logic [1:0]  state_b;
  logic [1:0]  count_b;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_phase_gen #(.CNT_W(16)) dut_a (
    .clk(clk), .rst_(rst_), .run_en(run_en), .step(step), .resume(resume), .halt(halt),
    .fetch(fetch_a), .cntrl_clk(cntrl_a), .alu_clk(alu_a), .inst_done(done_a),
    .phase(phase_a), .state(state_a), .inst_count(count_a)
  );

  cpu_phase_gen #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_(rst_), .run_en(run_en), .step(step), .resume(resume), .halt(halt),
    .fetch(fetch_b), .cntrl_clk(cntrl_b), .alu_clk(alu_b), .inst_done(done_b),
    .phase(phase_b), .state(state_b), .inst_count(count_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: mode uses the published state codes; pos is the position within an instruction cycle.
  localparam int M_STOP = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;
  int m_mode = M_STOP;
  int m_pos = 0;
  int m_total = 0;
  int m_done = 0;

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      m_mode <= M_STOP; m_pos <= 0; m_total <= 0; m_done <= 0;
    end else if (m_mode == M_RUN || m_mode == M_STEP) begin
      if (m_pos == 7) begin
        m_total <= m_total + 1;
        m_done  <= 1;
        m_pos   <= 0;
        m_mode  <= halt ? M_HALT : ((m_mode == M_RUN && run_en) ? M_RUN : M_STOP);
      end else begin
        m_pos  <= m_pos + 1;
        m_done <= 0;
      end
    end else begin
      m_done <= 0;
      m_pos  <= 0;
      if (m_mode == M_STOP) m_mode <= run_en ? M_RUN : (step ? M_STEP : M_STOP);
      else if (resume)      m_mode <= M_STOP;
    end
  end

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  always @(posedge clk) begin
    int act_m;
    int e_fetch, e_cntrl, e_alu;
    #1;
    act_m   = (m_mode == M_RUN || m_mode == M_STEP) ? 1 : 0;
    e_fetch = act_m & ((m_pos < 4) ? 1 : 0);
    e_cntrl = act_m & ((m_pos % 2 == 0) ? 1 : 0);
    e_alu   = act_m & ((m_pos / 2 == 2) ? 1 : 0);
    check("a.fetch", 32'(fetch_a), 32'(e_fetch));
    check("a.cntrl_clk", 32'(cntrl_a), 32'(e_cntrl));
    check("a.alu_clk", 32'(alu_a), 32'(e_alu));
    check("a.inst_done", 32'(done_a), 32'(m_done));
    check("a.phase", 32'(phase_a), 32'(m_pos));
    check("a.state", 32'(state_a), 32'(m_mode));
    check("a.inst_count", 32'(count_a), 32'(sat(m_total, 65535)));
    check("b.fetch", 32'(fetch_b), 32'(e_fetch));
    check("b.cntrl_clk", 32'(cntrl_b), 32'(e_cntrl));
    check("b.alu_clk", 32'(alu_b), 32'(e_alu));
    check("b.inst_done", 32'(done_b), 32'(m_done));
    check("b.phase", 32'(phase_b), 32'(m_pos));
    check("b.state", 32'(state_b), 32'(m_mode));
    check("b.inst_count", 32'(count_b), 32'(sat(m_total, 3)));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] f_seq, c_seq, a_seq;
    int cnt, pulses;
    logic [1:0] exp_b [5];
    exp_b = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // 1: reset held for 3 clocks
    repeat (3) tick();
    check("rst.state", 32'(state_a), 0);
    check("rst.phase", 32'(phase_a), 0);
    check("rst.outs", 32'({fetch_a, cntrl_a, alu_a, done_a}), 0);
    check("rst.count", 32'(count_a), 0);
    rst_ = 1'b1;
    tick();

    // 2: one run cycle, run_en held for one clock only
    run_en = 1'b1;
    tick();
    run_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f_seq[7-i] = fetch_a; c_seq[7-i] = cntrl_a; a_seq[7-i] = alu_a;
      check("run.phase", 32'(phase_a), 32'(i));
      tick();
    end
    check("run.fetch_seq", 32'(f_seq), 32'(8'b1111_0000));
    check("run.cntrl_seq", 32'(c_seq), 32'(8'b1010_1010));
    check("run.alu_seq", 32'(a_seq), 32'(8'b0000_1100));
    check("run.done", 32'(done_a), 1);
    check("run.count", 32'(count_a), 1);
    check("run.state", 32'(state_a), 0);
    tick();
    check("run.done_clear", 32'(done_a), 0);

    // 3: step, with a second step pulse at phase 3 that must be ignored
    cnt = 0;
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step = (state_a == 2'd2 && phase_a == 3'd3);
      if (state_a == 2'd2) cnt++;
      tick();
    end
    step = 1'b0;
    check("step.active_clks", 32'(cnt), 8);
    check("step.count", 32'(count_a), 2);
    check("step.state", 32'(state_a), 0);

    // 4: halt outside phase 7 ignored, halt at phase 7 captured, then resume
    run_en = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      halt = (i >= 2 && i <= 4);
      tick();
    end
    check("halt_ign.state", 32'(state_a), 1);
    check("halt_ign.done", 32'(done_a), 1);
    check("halt_ign.phase", 32'(phase_a), 0);
    check("halt_ign.fetch", 32'(fetch_a), 1);
    repeat (7) tick();
    check("halt.pre_phase", 32'(phase_a), 7);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt.state", 32'(state_a), 3);
    check("halt.done", 32'(done_a), 1);
    check("halt.outs", 32'({fetch_a, cntrl_a, alu_a}), 0);
    check("halt.count", 32'(count_a), 4);
    repeat (3) tick();
    check("halt.hold_state", 32'(state_a), 3);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume.state", 32'(state_a), 0);
    tick();
    check("resume.restart", 32'(state_a), 1);
    run_en = 1'b0;
    repeat (9) tick();
    check("resume.stopped", 32'(state_a), 0);

    // 5: fresh reset, 5 back-to-back cycles; the 2-bit counter saturates
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    run_en = 1'b1;
    tick();
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 8; j++) begin
        tick();
        pulses += int'(done_b);
      end
      check("sat.count_b", 32'(count_b), 32'(exp_b[k]));
    end
    check("sat.pulses", 32'(pulses), 5);
    check("sat.count_a", 32'(count_a), 5);
    run_en = 1'b0;
    repeat (9) tick();

    // 6: asynchronous reset at phase 5, between edges
    run_en = 1'b1;
    tick();
    repeat (5) tick();
    check("areset.pre_phase", 32'(phase_a), 5);
    #2;
    rst_ = 1'b0;
    #1;
    check("areset.outs", 32'({fetch_a, cntrl_a, alu_a, done_a}), 0);
    check("areset.phase", 32'(phase_a), 0);
    check("areset.state", 32'(state_a), 0);
    check("areset.count", 32'(count_a), 0);
    tick();
    rst_ = 1'b1;
    tick();
    check("areset.restart_phase", 32'(phase_a), 0);
    check("areset.restart_state", 32'(state_a), 1);
    check("areset.restart_fetch", 32'(fetch_a), 1);
    run_en = 1'b0;
    repeat (9) tick();
    check("areset.count_after", 32'(count_a), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_phase_gen.md
Name: cpu_phase_gen

Overview:
Timing generator that sits directly upstream of the VeriRISC CPU top level. It derives the CPU's `fetch`, `cntrl_clk` and `alu_clk` inputs from a single master clock as an 8-phase instruction cycle. It provides run, single-step, halt-capture and resume control, plus an instruction-completion counter for debug and bench use.

Parameters:
CNT_W, 16, width of inst_count; minimum 2.

Ports:
clk  input  1  master clock; all state updates on posedge.
rst_  input  1  asynchronous, active-low reset.
run_en  input  1  level; 1 requests continuous execution.
step  input  1  pulse; requests exactly one instruction cycle.
resume  input  1  pulse; leaves HALTED state.
halt  input  1  CPU halt output; sampled only at the instruction boundary.
fetch  output  1  to CPU fetch; 1 = instruction-fetch half of the cycle.
cntrl_clk  output  1  to CPU cntrl_clk.
alu_clk  output  1  to CPU alu_clk.
inst_done  output  1  one-clk pulse; an instruction cycle completed.
phase  output  3  current phase, 0..7.
state  output  2  0=STOPPED, 1=RUNNING, 2=STEPPING, 3=HALTED.
inst_count  output  CNT_W  completed instruction cycles; saturating.

Behaviour:
- Reset (async, rst_=0):
  - state=STOPPED, phase=0, inst_count=0.
  - fetch=cntrl_clk=alu_clk=inst_done=0.
  - Effect is immediate; no clk is required.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Active states are RUNNING and STEPPING.
- Phase handling:
  - While active, phase increments by 1 each clk, wrapping 7 -> 0.
  - While inactive, phase holds at 0.
- Output values while active, as a function of the registered phase p:
  - fetch = 1 for p in 0..3, else 0.
  - cntrl_clk = 1 for even p, else 0.
  - alu_clk = 1 for p in 4..5, else 0. Its falling edge therefore occurs on entry to p=6.
- Output values while inactive: fetch=cntrl_clk=alu_clk=0, with no glitches.
- Start edge (STOPPED -> active):
  - phase stays 0, and the outputs take their p=0 values on that same edge.
  - A full instruction cycle is 8 clk from the start edge.
- STOPPED:
  - run_en=1 -> RUNNING.
  - else step=1 -> STEPPING.
  - run_en and step both 1 -> RUNNING (run has priority).
  - resume is ignored.
- Boundary edge: an edge where the state is active and phase==7.
  - phase -> 0.
  - inst_done=1 for exactly one clk.
  - inst_count increments; it holds at all-ones once saturated (no wrap).
- Next state at a boundary edge:
  - halt=1 -> HALTED. halt has priority over run_en and step.
  - RUNNING with run_en=0 -> STOPPED.
  - RUNNING with run_en=1 -> RUNNING; the next instruction starts with no gap, and p=0 outputs are driven on this same edge.
  - STEPPING -> STOPPED.
- Inside active states:
  - Dropping run_en mid-cycle takes effect only at the boundary edge; an instruction is never truncated.
  - step is ignored while active.
  - halt is ignored when phase != 7.
- HALTED:
  - Outputs are idle and phase=0.
  - run_en and step are ignored.
  - resume=1 -> STOPPED on the next edge. If run_en is still 1, execution restarts on the following edge.
- inst_done is 0 at all edges other than boundary edges.
- Reset asserted mid-cycle: the cycle is abandoned, inst_count is cleared, and no inst_done is issued.

Test Plan:
1. Reset, then hold rst_=0 for 3 clk.
   -> state=0, phase=0, all outputs 0, inst_count=0.
2. rst_=1, run_en=1 for 1 clk, then run_en=0.
   -> phases 0..7 in 8 clk.
   -> fetch 1,1,1,1,0,0,0,0; cntrl_clk 1,0,1,0,1,0,1,0; alu_clk 0,0,0,0,1,1,0,0.
   -> inst_done pulses once; inst_count=1; state returns to 0.
3. step pulse while STOPPED, and a second step pulse at phase 3.
   -> exactly 8 active clk; inst_count increments by 1; state 2 -> 0.
4. run_en=1 held; halt=1 during phases 2..4 only.
   -> ignored; the next cycle starts with no gap.
   -> Then halt=1 at phase 7: state=3, outputs idle, inst_done=1 on that edge.
   -> run_en=1 stays ignored; a resume pulse gives state 0, then RUNNING on the next clk.
5. CNT_W=2, run_en=1 for 5 full instruction cycles.
   -> inst_count sequence 1,2,3,3,3; inst_done pulses 5 times.
6. run_en=1; assert rst_=0 asynchronously at phase 5, between clk edges.
   -> all outputs 0 immediately, inst_count=0.
   -> After release with run_en=1, the cycle restarts at phase 0.
